post_sym_align: RTL and testbench

POST_SYM_ALIGN -- requirements
Module: post_sym_align

---
 rtl/post_sym_align.sv | 107 ++++++++++
 tb/tb_post_sym_align.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/post_sym_align.sv
// Sign-tag FIFO that re-applies the input sign (odd/even/complement symmetry) to
// core results. Optional saturation of the folded result: define POST_SYM_SAT_EN.
module post_sym_align #(
    parameter int M         = 4,
    parameter int N         = 8,
    parameter int FUNC_TYPE = 0,
    parameter int DEPTH     = 8,
    localparam int W        = M + N,
    localparam int AW       = $clog2(DEPTH),
    localparam int CW       = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic          s_sign,
    input  logic          r_valid,
    output logic          r_ready,
    input  logic [W-1:0]  r_data,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [W-1:0]  o_data,
    output logic [CW-1:0] count
);

    localparam logic [W:0] ONE = {{W{1'b0}}, 1'b1} << N;

    logic          tag_mem_reg [DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg, count_next;
    logic          o_valid_reg;
    logic [W-1:0]  o_data_reg;

    logic          push, pop, head_sign;
    logic [W:0]    ext, res;
    logic [W-1:0]  fold_w;

    assign s_ready = (count_reg != CW'(DEPTH));
    assign r_ready = (count_reg != '0) && (!o_valid_reg || o_ready);
    assign push    = s_valid && s_ready;
    assign pop     = r_valid && r_ready;

    assign head_sign = tag_mem_reg[rd_ptr_reg];
    assign o_valid   = o_valid_reg;
    assign o_data    = o_data_reg;
    assign count     = count_reg;

    always_comb begin
        count_next = count_reg;
        if (push && !pop)
            count_next = count_reg + CW'(1);
        else if (pop && !push)
            count_next = count_reg - CW'(1);
    end

    // Fold in W+1 bits so negation of the most negative value and ONE - x stay exact.
    always_comb begin
        ext = {r_data[W-1], r_data};
        res = ext;
        case (FUNC_TYPE)
            0:       res = head_sign ? ((W+1)'(0) - ext) : ext;
            2:       res = head_sign ? (ONE - ext) : ext;
            default: res = ext;
        endcase
    end

`ifdef POST_SYM_SAT_EN
    always_comb begin
        fold_w = res[W-1:0];
        if (res[W] != res[W-1])
            fold_w = res[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
`else
    logic unused_msb;
    assign unused_msb = res[W];
    assign fold_w     = res[W-1:0];
`endif

    // Tag storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push)
            tag_mem_reg[wr_ptr_reg] <= s_sign;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            o_valid_reg <= 1'b0;
            o_data_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_next;
            if (pop) begin
                o_valid_reg <= 1'b1;
                o_data_reg  <= fold_w;
            end else if (o_ready) begin
                o_valid_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_post_sym_align.sv
// Directed bench for post_sym_align: three instances (odd, even, complement)
// share stimulus; a vector table covers the folding rules, hand sequences the FIFO corners.
module tb_post_sym_align;

    localparam int W  = 12;
    localparam int CW = 4;

`ifdef POST_SYM_SAT_EN
    localparam logic [W-1:0] E0_NEG_MIN = 12'h7FF;
    localparam logic [W-1:0] E2_NEG_MIN = 12'h7FF;
`else
    localparam logic [W-1:0] E0_NEG_MIN = 12'h800;
    localparam logic [W-1:0] E2_NEG_MIN = 12'h900;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid, s_sign, r_valid, o_ready;
    logic [W-1:0]  r_data;
    logic          s_ready  [3];
    logic          r_ready  [3];
    logic          o_valid  [3];
    logic [W-1:0]  o_data   [3];
    logic [CW-1:0] count    [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        post_sym_align #(.M(4), .N(8), .FUNC_TYPE(gi), .DEPTH(8)) dut (
            .clk     (clk),
            .rst     (rst),
            .s_valid (s_valid),
            .s_ready (s_ready[gi]),
            .s_sign  (s_sign),
            .r_valid (r_valid),
            .r_ready (r_ready[gi]),
            .r_data  (r_data),
            .o_valid (o_valid[gi]),
            .o_ready (o_ready),
            .o_data  (o_data[gi]),
            .count   (count[gi])
        );
    end

    typedef struct {
        logic         sg;
        logic [W-1:0] rd;
        logic [W-1:0] e0;
        logic [W-1:0] e1;
        logic [W-1:0] e2;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{1'b1, 12'h100, 12'hF00, 12'h100, 12'h000};
        vecs[1] = '{1'b0, 12'h100, 12'h100, 12'h100, 12'h100};
        vecs[2] = '{1'b1, 12'h040, 12'hFC0, 12'h040, 12'h0C0};
        vecs[3] = '{1'b0, 12'h040, 12'h040, 12'h040, 12'h040};
        vecs[4] = '{1'b1, 12'h800, E0_NEG_MIN, 12'h800, E2_NEG_MIN};
        vecs[5] = '{1'b1, 12'h7FF, 12'h801, 12'h7FF, 12'h901};
        vecs[6] = '{1'b1, 12'hFFF, 12'h001, 12'hFFF, 12'h101};
        vecs[7] = '{1'b0, 12'h800, 12'h800, 12'h800, 12'h800};
        vecs[8] = '{1'b1, 12'h000, 12'h000, 12'h000, 12'h100};

        rst = 1'b1; s_valid = 1'b0; s_sign = 1'b0; r_valid = 1'b0;
        r_data = '0; o_ready = 1'b1;
        @(negedge clk);
        chk("rst count",   32'(count[0]),   32'd0);
        chk("rst o_valid", 32'(o_valid[0]), 32'd0);
        chk("rst o_data",  32'(o_data[0]),  32'd0);
        chk("rst s_ready", 32'(s_ready[0]), 32'd1);
        chk("rst r_ready", 32'(r_ready[0]), 32'd0);
        rst = 1'b0;
        tick();

        // Table: push one tag, accept its result, check all three fold modes.
        for (int i = 0; i < 9; i++) begin
            s_valid = 1'b1; s_sign = vecs[i].sg;
            tick();
            s_valid = 1'b0;
            chk("vec count1",  32'(count[0]),   32'd1);
            chk("vec r_ready", 32'(r_ready[0]), 32'd1);
            r_valid = 1'b1; r_data = vecs[i].rd;
            tick();
            r_valid = 1'b0;
            chk("vec o_valid", 32'(o_valid[0]), 32'd1);
            chk("vec odd",     32'(o_data[0]),  32'(vecs[i].e0));
            chk("vec even",    32'(o_data[1]),  32'(vecs[i].e1));
            chk("vec compl",   32'(o_data[2]),  32'(vecs[i].e2));
            chk("vec count0",  32'(count[0]),   32'd0);
            $display("vec %0d sg=%0b r=%03h -> odd=%03h even=%03h compl=%03h",
                     i, vecs[i].sg, vecs[i].rd, o_data[0], o_data[1], o_data[2]);
            tick();
            chk("vec o_valid drop", 32'(o_valid[0]), 32'd0);
        end

        // Complement mode: tags consumed in order.
        s_valid = 1'b1; s_sign = 1'b1; tick();
        s_sign = 1'b0; tick();
        s_valid = 1'b0;
        chk("order count", 32'(count[2]), 32'd2);
        r_valid = 1'b1; r_data = 12'h040; tick();
        chk("order first", 32'(o_data[2]), 32'h0C0);
        tick();
        r_valid = 1'b0;
        chk("order second", 32'(o_data[2]), 32'h040);
        chk("order valid",  32'(o_valid[2]), 32'd1);
        tick();
        $display("seq order done");

        // Fill to full, ignored 9th push, pop-at-full, simultaneous push/pop, drain.
        s_valid = 1'b1; s_sign = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("full count",   32'(count[0]),   32'd8);
        chk("full s_ready", 32'(s_ready[0]), 32'd0);
        tick();
        chk("ninth ignored", 32'(count[0]), 32'd8);
        r_valid = 1'b1; r_data = 12'h010;
        tick();
        chk("pop at full count", 32'(count[0]),   32'd7);
        chk("pop at full ready", 32'(s_ready[0]), 32'd1);
        tick();
        chk("push+pop count", 32'(count[0]), 32'd7);
        s_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        r_valid = 1'b0;
        chk("drain count", 32'(count[0]), 32'd0);
        tick();
        $display("seq full done");

        // Output hold under back-pressure.
        s_valid = 1'b1; s_sign = 1'b1; tick();
        tick();
        s_valid = 1'b0;
        o_ready = 1'b0; r_valid = 1'b1; r_data = 12'h020;
        tick();
        r_data = 12'h030;
        chk("bp r_ready", 32'(r_ready[0]), 32'd0);
        tick();
        chk("bp hold valid", 32'(o_valid[0]), 32'd1);
        chk("bp hold data",  32'(o_data[0]),  32'hFE0);
        chk("bp count",      32'(count[0]),   32'd1);
        r_valid = 1'b0; o_ready = 1'b1;
        tick();
        r_valid = 1'b1; tick();
        r_valid = 1'b0;
        chk("bp next data", 32'(o_data[0]), 32'hFD0);
        tick();
        $display("seq backpressure done");

        // Result offered with FIFO empty is not accepted; no push-to-pop bypass.
        r_valid = 1'b1; r_data = 12'h100;
        chk("empty r_ready", 32'(r_ready[0]), 32'd0);
        tick();
        chk("empty o_valid", 32'(o_valid[0]), 32'd0);
        s_valid = 1'b1; s_sign = 1'b1;
        tick();
        s_valid = 1'b0;
        chk("no bypass o_valid",  32'(o_valid[0]), 32'd0);
        chk("after push r_ready", 32'(r_ready[0]), 32'd1);
        tick();
        r_valid = 1'b0;
        chk("late pair data", 32'(o_data[0]), 32'hF00);
        tick();
        $display("seq empty done");

        // Asynchronous reset mid-operation with pending output.
        s_valid = 1'b1; s_sign = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        s_valid = 1'b0; o_ready = 1'b0; r_valid = 1'b1; r_data = 12'h055;
        tick();
        r_valid = 1'b0;
        chk("pre-rst count", 32'(count[0]),   32'd3);
        chk("pre-rst valid", 32'(o_valid[0]), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("async count",   32'(count[0]),   32'd0);
        chk("async o_valid", 32'(o_valid[0]), 32'd0);
        chk("async o_data",  32'(o_data[0]),  32'd0);
        chk("async r_ready", 32'(r_ready[0]), 32'd0);
        #1 rst = 1'b0;
        o_ready = 1'b1;
        @(negedge clk);
        s_valid = 1'b1; s_sign = 1'b1; tick();
        s_valid = 1'b0; r_valid = 1'b1; r_data = 12'h100; tick();
        r_valid = 1'b0;
        chk("post-rst data",  32'(o_data[0]),  32'hF00);
        chk("post-rst valid", 32'(o_valid[0]), 32'd1);
        tick();
        chk("post-rst drop", 32'(o_valid[0]), 32'd0);
        $display("seq async reset done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
